// File: rtl/pixel_group_scheduler.sv
// Round-robin group arbiter and per-pixel event server for a ROWS x COLS pixel request matrix.
// Define PIXEL_GRP_TS_EN to latch a free-running timestamp into ts_o at each event load.
module pixel_group_scheduler #(
    parameter  int ROWS      = 8,
    parameter  int COLS      = 8,
    parameter  int GRP_ROWS  = 4,
    parameter  int GRP_COLS  = 4,
    parameter  int MAX_BURST = 4,
    parameter  int TS_W      = 16,
    localparam int GR        = ROWS / GRP_ROWS,
    localparam int GC        = COLS / GRP_COLS,
    localparam int NGRP      = GR * GC,
    localparam int X_W       = $clog2(ROWS),
    localparam int Y_W       = $clog2(COLS),
    localparam int G_W       = (NGRP > 1) ? $clog2(NGRP) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic [ROWS-1:0][COLS-1:0] set_i,
    output logic                      req_o,
    output logic [GR-1:0][GC-1:0]     grp_req_o,
    output logic                      evt_valid_o,
    input  logic                      evt_ready_i,
    output logic [X_W-1:0]            x_add_o,
    output logic [Y_W-1:0]            y_add_o,
    output logic [G_W-1:0]            grp_o,
    output logic [ROWS-1:0][COLS-1:0] gnt_o,
    output logic                      active_o,
    output logic                      grp_release_o,
    output logic [TS_W-1:0]           ts_o
);

    localparam int GSIZE = GRP_ROWS * GRP_COLS;
    localparam int L_W   = (GSIZE > 1) ? $clog2(GSIZE) : 1;
    localparam int B_W   = $clog2(GSIZE + 1);

    if (ROWS % GRP_ROWS != 0) begin : g_bad_rows
        $error("ROWS must be a multiple of GRP_ROWS");
    end
    if (COLS % GRP_COLS != 0) begin : g_bad_cols
        $error("COLS must be a multiple of GRP_COLS");
    end

    typedef enum logic [1:0] {IDLE, SELECT, SERVE, RELEASE} state_t;

    state_t                       state, state_nxt;
    logic [NGRP-1:0][GSIZE-1:0]   grp_mask;
    logic [NGRP-1:0]              grp_req_flat;
    logic [G_W-1:0]               cur_grp, last_grp, sel_grp, cand_grp;
    logic                         sel_found;
    logic [GSIZE-1:0]             pending;
    logic [L_W-1:0]               ptr [NGRP];
    logic [L_W-1:0]               pix_loc, cand_loc;
    logic [B_W-1:0]               burst_cnt;
    logic                         handshake, slot_free, burst_hit;
    logic                         load_evt, serve_done;
    logic [X_W-1:0]               x_nxt;
    logic [Y_W-1:0]               y_nxt;

    // Regroup the flat matrix into per-group local masks (local index = row * GRP_COLS + col).
    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        for (genvar lr = 0; lr < GRP_ROWS; lr++) begin : g_lr
            for (genvar lc = 0; lc < GRP_COLS; lc++) begin : g_lc
                assign grp_mask[g][lr*GRP_COLS+lc] =
                    set_i[(g/GC)*GRP_ROWS+lr][(g%GC)*GRP_COLS+lc];
            end
        end
        assign grp_req_flat[g]          = |grp_mask[g];
        assign grp_req_o[g/GC][g%GC]    = grp_req_flat[g];
    end

    assign req_o = |set_i;

    // Descending scan so the candidate closest after last_grp is the one left standing.
    always_comb begin
        sel_found = 1'b0;
        sel_grp   = '0;
        cand_grp  = '0;
        for (int i = NGRP; i >= 1; i--) begin
            cand_grp = G_W'((int'(last_grp) + i) % NGRP);
            if (grp_req_flat[cand_grp]) begin
                sel_found = 1'b1;
                sel_grp   = cand_grp;
            end
        end
    end

    always_comb begin
        pix_loc  = '0;
        cand_loc = '0;
        for (int i = GSIZE - 1; i >= 0; i--) begin
            cand_loc = L_W'((int'(ptr[cur_grp]) + i) % GSIZE);
            if (pending[cand_loc]) begin
                pix_loc = cand_loc;
            end
        end
    end

    assign x_nxt = X_W'((int'(cur_grp) / GC) * GRP_ROWS + int'(pix_loc) / GRP_COLS);
    assign y_nxt = Y_W'((int'(cur_grp) % GC) * GRP_COLS + int'(pix_loc) % GRP_COLS);

    assign handshake = evt_valid_o && evt_ready_i;
    assign slot_free = !evt_valid_o || handshake;
    assign burst_hit = (MAX_BURST != 0) && (int'(burst_cnt) == MAX_BURST);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable_i && req_o) state_nxt = SELECT;
            SELECT:  state_nxt = sel_found ? SERVE : IDLE;
            SERVE:   if (serve_done) state_nxt = RELEASE;
            RELEASE: state_nxt = (enable_i && req_o) ? SELECT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Load and release are mutually exclusive: a release needs an empty slot and nothing left to load.
    always_comb begin
        active_o      = (state != IDLE);
        grp_release_o = (state == RELEASE);
        load_evt      = (state == SERVE) && enable_i && slot_free && (|pending) && !burst_hit;
        serve_done    = (state == SERVE) && slot_free && (!(|pending) || burst_hit || !enable_i);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cur_grp     <= '0;
            last_grp    <= G_W'(NGRP - 1);
            pending     <= '0;
            burst_cnt   <= '0;
            evt_valid_o <= 1'b0;
            x_add_o     <= '0;
            y_add_o     <= '0;
            grp_o       <= '0;
            for (int g = 0; g < NGRP; g++) begin
                ptr[g] <= '0;
            end
        end else begin
            if (state == SELECT && sel_found) begin
                cur_grp   <= sel_grp;
                pending   <= grp_mask[sel_grp];
                burst_cnt <= '0;
            end
            if (state == RELEASE) begin
                last_grp <= cur_grp;
            end
            if (load_evt) begin
                pending[pix_loc] <= 1'b0;
                burst_cnt        <= burst_cnt + B_W'(1);
                ptr[cur_grp]     <= L_W'((int'(pix_loc) + 1) % GSIZE);
                evt_valid_o      <= 1'b1;
                x_add_o          <= x_nxt;
                y_add_o          <= y_nxt;
                grp_o            <= cur_grp;
            end else if (handshake) begin
                evt_valid_o <= 1'b0;
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_gnt_r
        for (genvar c = 0; c < COLS; c++) begin : g_gnt_c
            assign gnt_o[r][c] = handshake && (x_add_o == X_W'(r)) && (y_add_o == Y_W'(c));
        end
    end

`ifdef PIXEL_GRP_TS_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ts_cnt <= '0;
            ts_o   <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (load_evt) begin
                ts_o <= ts_cnt;
            end
        end
    end
`else
    assign ts_o = '0;
`endif

endmodule

// File: tb/tb_pixel_group_scheduler.sv
// Directed bench for pixel_group_scheduler: 8x8 matrix, 4x4 groups, burst limit of two events.
// A small pixel-array model drops each set_i bit once its gnt_o pulse has been seen.
module tb_pixel_group_scheduler;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              enable_i;
    logic [7:0][7:0]   set_i;
    logic              req_o;
    logic [1:0][1:0]   grp_req_o;
    logic              evt_valid_o;
    logic              evt_ready_i;
    logic [2:0]        x_add_o;
    logic [2:0]        y_add_o;
    logic [1:0]        grp_o;
    logic [7:0][7:0]   gnt_o;
    logic              active_o;
    logic              grp_release_o;
    logic [15:0]       ts_o;

    int                errors = 0;
    int                checks = 0;
    logic [63:0]       snap_gnt = '0;

    always #5 clk_i = ~clk_i;

    pixel_group_scheduler #(
        .ROWS(8), .COLS(8), .GRP_ROWS(4), .GRP_COLS(4), .MAX_BURST(2), .TS_W(16)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .set_i(set_i),
        .req_o(req_o), .grp_req_o(grp_req_o), .evt_valid_o(evt_valid_o),
        .evt_ready_i(evt_ready_i), .x_add_o(x_add_o), .y_add_o(y_add_o),
        .grp_o(grp_o), .gnt_o(gnt_o), .active_o(active_o),
        .grp_release_o(grp_release_o), .ts_o(ts_o)
    );

    function automatic logic [63:0] pix(input int r, input int c);
        return 64'd1 << (r * 8 + c);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic rdy, input logic [63:0] new_pix);
        enable_i    = en;
        evt_ready_i = rdy;
        set_i       = set_i | new_pix;
    endtask

    // Captures the cycle's gnt_o mid-cycle, crosses one rising edge, then retires acknowledged pixels.
    task automatic tick();
        #1;
        snap_gnt = gnt_o;
        @(posedge clk_i);
        #1;
        set_i = set_i & ~snap_gnt;
    endtask

    task automatic collectEvent(input string tag, input int ex, input int ey, input int eg, input int exp_wait);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!evt_valid_o && n < 20);
        checkOutput($sformatf("%s_valid", tag), 64'(evt_valid_o), 64'd1);
        checkOutput($sformatf("%s_x", tag),     64'(x_add_o),     64'(ex));
        checkOutput($sformatf("%s_y", tag),     64'(y_add_o),     64'(ey));
        checkOutput($sformatf("%s_grp", tag),   64'(grp_o),       64'(eg));
        checkOutput($sformatf("%s_wait", tag),  64'(n),           64'(exp_wait));
    endtask

    task automatic checkRelease(input string tag);
        tick();
        checkOutput($sformatf("%s_rel", tag),   64'(grp_release_o), 64'd1);
        checkOutput($sformatf("%s_relv", tag),  64'(evt_valid_o),   64'd0);
    endtask

    task automatic checkIdle(input string tag);
        tick();
        checkOutput($sformatf("%s_idle", tag),  64'(active_o),      64'd0);
        checkOutput($sformatf("%s_idler", tag), 64'(grp_release_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, wanted finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_i     = 1'b0;
        enable_i    = 1'b0;
        evt_ready_i = 1'b0;
        set_i       = '0;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_valid",  64'(evt_valid_o),   64'd0);
        checkOutput("rst_active", 64'(active_o),      64'd0);
        checkOutput("rst_rel",    64'(grp_release_o), 64'd0);
        checkOutput("rst_gnt",    64'(gnt_o),         64'd0);
        checkOutput("rst_x",      64'(x_add_o),       64'd0);
        checkOutput("rst_grp",    64'(grp_o),         64'd0);
        checkOutput("rst_ts",     64'(ts_o),          64'd0);
        checkOutput("rst_req",    64'(req_o),         64'd0);
        reset_i = 1'b1;

        // Single pixel in group 3: exact latency, one-cycle gnt, release one cycle later.
        applyStimulus(1'b1, 1'b1, pix(5, 6));
        #1;
        checkOutput("t1_req",    64'(req_o),     64'd1);
        checkOutput("t1_grpreq", 64'(grp_req_o), 64'h8);
        tick();
        checkOutput("t1_sel_active", 64'(active_o),    64'd1);
        checkOutput("t1_sel_valid",  64'(evt_valid_o), 64'd0);
        tick();
        checkOutput("t1_srv_valid",  64'(evt_valid_o), 64'd0);
        tick();
        checkOutput("t1_valid", 64'(evt_valid_o), 64'd1);
        checkOutput("t1_x",     64'(x_add_o),     64'd5);
        checkOutput("t1_y",     64'(y_add_o),     64'd6);
        checkOutput("t1_grp",   64'(grp_o),       64'd3);
        tick();
        checkOutput("t1_gnt", snap_gnt, pix(5, 6));
        checkOutput("t1_rel", 64'(grp_release_o), 64'd1);
        checkOutput("t1_relv", 64'(evt_valid_o),  64'd0);
        tick();
        checkOutput("t1_gnt_once", snap_gnt, 64'd0);
        checkOutput("t1_idle",     64'(active_o), 64'd0);

        // One pixel in each of groups 0, 1, 3, then a group-0 pixel arriving during group 3.
        applyStimulus(1'b1, 1'b1, pix(1, 1) | pix(2, 5) | pix(6, 6));
        collectEvent("t3_g0", 1, 1, 0, 3);
        collectEvent("t3_g1", 2, 5, 1, 4);
        collectEvent("t3_g3", 6, 6, 3, 4);
        applyStimulus(1'b1, 1'b1, pix(2, 3));
        collectEvent("t3_wrap", 2, 3, 0, 4);
        checkRelease("t3");
        checkIdle("t3");

        // Two pixels with the sink stalled: address held, then back-to-back events with their gnts.
        applyStimulus(1'b1, 1'b0, pix(0, 0) | pix(0, 1));
        collectEvent("t2_first", 0, 0, 0, 3);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("t2_hold%0d_v", k), 64'(evt_valid_o), 64'd1);
            checkOutput($sformatf("t2_hold%0d_x", k), 64'(x_add_o),     64'd0);
            checkOutput($sformatf("t2_hold%0d_y", k), 64'(y_add_o),     64'd0);
            checkOutput($sformatf("t2_hold%0d_g", k), snap_gnt,         64'd0);
        end
        applyStimulus(1'b1, 1'b1, 64'd0);
        tick();
        checkOutput("t2_gnt0", snap_gnt, pix(0, 0));
        checkOutput("t2_v1",   64'(evt_valid_o), 64'd1);
        checkOutput("t2_x1",   64'(x_add_o),     64'd0);
        checkOutput("t2_y1",   64'(y_add_o),     64'd1);
        tick();
        checkOutput("t2_gnt1", snap_gnt, pix(0, 1));
        checkOutput("t2_rel",  64'(grp_release_o), 64'd1);
        checkIdle("t2");

        // Enable dropped while an event is stalled: it completes, then the scheduler parks in IDLE.
        applyStimulus(1'b1, 1'b0, pix(4, 4) | pix(5, 5));
        collectEvent("t5_first", 4, 4, 3, 3);
        applyStimulus(1'b0, 1'b0, 64'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput($sformatf("t5_hold%0d_v", k), 64'(evt_valid_o), 64'd1);
            checkOutput($sformatf("t5_hold%0d_y", k), 64'(y_add_o),     64'd4);
        end
        applyStimulus(1'b0, 1'b1, 64'd0);
        tick();
        checkOutput("t5_gnt", snap_gnt, pix(4, 4));
        checkOutput("t5_rel", 64'(grp_release_o), 64'd1);
        checkOutput("t5_relv", 64'(evt_valid_o),  64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("t5_park%0d_a", k), 64'(active_o),    64'd0);
            checkOutput($sformatf("t5_park%0d_v", k), 64'(evt_valid_o), 64'd0);
        end
        checkOutput("t5_req",    64'(req_o),     64'd1);
        checkOutput("t5_grpreq", 64'(grp_req_o), 64'h8);
        applyStimulus(1'b1, 1'b1, 64'd0);
        collectEvent("t5_resume", 5, 5, 3, 3);
        checkRelease("t5");
        checkIdle("t5");

        // Burst cut at two events: group 0 twice, group 1 once, then the rest of group 0.
        applyStimulus(1'b1, 1'b1, pix(1, 0) | pix(1, 1) | pix(2, 2) | pix(3, 3) | pix(0, 4));
        collectEvent("t4_a", 1, 0, 0, 3);
        collectEvent("t4_b", 1, 1, 0, 1);
        checkRelease("t4_cut");
        collectEvent("t4_g1", 0, 4, 1, 3);
        checkRelease("t4_g1");
        collectEvent("t4_c", 2, 2, 0, 3);
        collectEvent("t4_d", 3, 3, 0, 1);
        checkRelease("t4_end");
        checkIdle("t4");

        // Reset during a stalled group-1 event: outputs clear at once, service restarts at group 0.
        applyStimulus(1'b1, 1'b0, pix(0, 0) | pix(0, 5));
        collectEvent("t6_pre", 0, 5, 1, 3);
        tick();
        checkOutput("t6_held", 64'(evt_valid_o), 64'd1);
        evt_ready_i = 1'b1;
        reset_i     = 1'b0;
        #1;
        checkOutput("t6_rst_valid",  64'(evt_valid_o), 64'd0);
        checkOutput("t6_rst_active", 64'(active_o),    64'd0);
        checkOutput("t6_rst_gnt",    64'(gnt_o),       64'd0);
        checkOutput("t6_rst_grp",    64'(grp_o),       64'd0);
        tick();
        checkOutput("t6_rst_gnt2",   snap_gnt,         64'd0);
        checkOutput("t6_rst_active2", 64'(active_o),   64'd0);
        reset_i = 1'b1;
        collectEvent("t6_restart", 0, 0, 0, 3);
        collectEvent("t6_after",   0, 5, 1, 4);
        checkRelease("t6");
        checkIdle("t6");

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
